rotor_stage: RTL and testbench
==============================

Name: rotor_stage

Overview:
- Parametrised, registered successor to the fixed Rotor II wiring filter.
- One Enigma rotor with a run-time loadable wiring table, position counter, ring setting and turnover notch.
- Translates one-hot symbols on a forward path (toward the reflector) and an inverse path (from the reflector), with position-dependent offset.
- Chained by the machine controller; `carry_out` and `at_notch` drive the next rotor's stepping.

Parameters:
- N_SYM, 26, alphabet size; one-hot bus width.
- IW, $clog2(N_SYM), index width (derived; do not override).
- NOTCH_RST, 4, notch index loaded at reset (4 = E, Rotor II turnover).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fwd_in  in  N_SYM  one-hot forward symbol
- fwd_vld  in  1  fwd_in valid
- inv_in  in  N_SYM  one-hot inverse symbol
- inv_vld  in  1  inv_in valid
- fwd_out  out  N_SYM  registered one-hot forward result
- fwd_out_vld  out  1  fwd_out valid
- inv_out  out  N_SYM  registered one-hot inverse result
- inv_out_vld  out  1  inv_out valid
- sym_err  out  1  pulse: a valid input was not exactly one-hot
- step_in  in  1  advance position by one
- pos_load  in  1  load position from pos_val
- pos_val  in  IW  position to load
- ring_load  in  1  load ring setting from pos_val
- notch_load  in  1  load notch index from pos_val
- cfg_we  in  1  wiring table write
- cfg_addr  in  IW  contact index written
- cfg_data  in  IW  mapped index for that contact
- pos  out  IW  current position
- at_notch  out  1  combinational: pos == notch
- carry_out  out  1  registered pulse: a step occurred from the notch position

Behaviour:
- **Reset.** Forward table `wire[i]=i`; inverse table `winv[i]=i`; pos=0, ring=0, notch=NOTCH_RST. All outputs are 0: fwd_out, inv_out, both valids, sym_err, carry_out.
- **Offset arithmetic.** shift = (pos − ring) mod N_SYM. All additions and subtractions are mod N_SYM, computed with one conditional add/subtract of N_SYM and no truncation wrap.
- **Forward path.** idx = onehot→index(fwd_in); c = (idx + shift) mod N; o = (wire[c] − shift) mod N. fwd_out = onehot(o).
- **Inverse path.** Same as forward, using winv.
- **Latency.** Exactly 1 cycle. x_out_vld(t+1) = x_vld(t). Outputs are computed from pos, ring and tables as held in cycle t, i.e. before any same-cycle step or load takes effect.
- **Independence.** Forward and inverse paths are independent and may be valid in the same cycle. Throughput is one symbol per path per cycle.
- **Invalid symbol.** If x_vld=1 and x_in is zero or multi-hot:
  - x_out = 0 and x_out_vld = 1 next cycle;
  - sym_err pulses for 1 cycle (OR of both paths).
- **When not valid.** Outputs hold 0 when the corresponding valid is low.
- **Table write.** cfg_we writes wire[cfg_addr]=cfg_data and winv[cfg_data]=cfg_addr in the same edge. The write is visible to inputs sampled the next cycle. cfg_addr or cfg_data ≥ N_SYM: the write is ignored.
- **Position update priority:** reset > pos_load > step_in.
  - pos_load: pos ← pos_val.
  - step_in: pos ← (pos + 1) mod N, wrapping N−1 → 0.
  - ring_load and notch_load: load ring / notch from pos_val; may coincide with a pos update.
  - Any *_load with pos_val ≥ N_SYM is ignored.
- **Carry.** carry_out(t+1) = step_in(t) & ~pos_load(t) & (pos(t) == notch). Double-stepping is the controller's job, using at_notch.

Optional Feature:
- Macro: ROTOR_PERM_CHECK_EN.
- When defined:
  - Adds output `wire_ok` (1 bit, registered; reset value 1).
  - A cfg_we is not applied if its cfg_data is already mapped from a different address.
  - A cfg_we is not applied if applying it would orphan the old target, i.e. the forward table would stop being a permutation.
  - A rejected write leaves both tables unchanged and clears wire_ok.
  - wire_ok returns to 1 only on reset, or on the first subsequent write that is applied.
- When undefined: no wire_ok port, and writes are applied unconditionally per the table-write rule above.

Test Plan:
- Load Rotor II wiring AJDKSIRUXBLHWTMCQGZNPYFVOE with pos=0, ring=0; forward A,B,C → A,J,D next cycle; inverse J → B.
- pos=1, ring=0, forward A → I; pos=0, ring=1, forward A → F.
- pos=4, notch=4, step_in → pos=5, carry_out=1 for one cycle. pos=25, step_in → pos=0, carry_out=0.
- step_in and fwd_vld in the same cycle at pos=0: the result uses pos=0 (A→A), then pos=1. pos_load=7 with step_in → pos=7, no carry.
- fwd_in=0 with fwd_vld, and inv_in multi-hot 0x3 with inv_vld → both outputs 0 with valids 1, sym_err=1 for one cycle.
- With ROTOR_PERM_CHECK_EN defined, identity table, write addr0←1 → rejected, wire_ok=0, A→A still. Assert reset mid-stream → all outputs 0 the next cycle and identity wiring.

Source files
------------

// File: rtl/rotor_stage.sv
// One Enigma rotor stage: loadable wiring, position/ring/notch, 1-cycle forward and inverse paths.
// Optional macro ROTOR_PERM_CHECK_EN rejects wiring writes that would break the permutation and adds wire_ok.
module rotor_stage #(
    parameter int unsigned N_SYM     = 26,
    parameter int unsigned IW        = $clog2(N_SYM),
    parameter int unsigned NOTCH_RST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SYM-1:0] fwd_in,
    input  logic             fwd_vld,
    input  logic [N_SYM-1:0] inv_in,
    input  logic             inv_vld,
    output logic [N_SYM-1:0] fwd_out,
    output logic             fwd_out_vld,
    output logic [N_SYM-1:0] inv_out,
    output logic             inv_out_vld,
    output logic             sym_err,
    input  logic             step_in,
    input  logic             pos_load,
    input  logic [IW-1:0]    pos_val,
    input  logic             ring_load,
    input  logic             notch_load,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_addr,
    input  logic [IW-1:0]    cfg_data,
    output logic [IW-1:0]    pos,
    output logic             at_notch,
    output logic             carry_out
`ifdef ROTOR_PERM_CHECK_EN
    ,
    output logic             wire_ok
`endif
);

    localparam logic [IW:0] NW = (IW+1)'(N_SYM);

    logic [IW-1:0]    wire_q [N_SYM];
    logic [IW-1:0]    winv_q [N_SYM];
    logic [IW-1:0]    pos_q, pos_d;
    logic [IW-1:0]    ring_q, ring_d;
    logic [IW-1:0]    notch_q, notch_d;
    logic             carry_q, carry_d;
    logic [N_SYM-1:0] fwd_out_q, fwd_out_d;
    logic [N_SYM-1:0] inv_out_q, inv_out_d;
    logic             fwd_vld_q, inv_vld_q;
    logic             sym_err_q, sym_err_d;
    logic             wr_apply;

    // Modular helpers: one conditional correction, no reliance on bit-width wrap.
    function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NW) s = s - NW;
        return IW'(s);
    endfunction

    function automatic logic [IW-1:0] sub_mod(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + NW - {1'b0, b};
        return IW'(s);
    endfunction

    logic [IW-1:0] shift_c;
    logic [IW-1:0] fwd_idx, inv_idx, fwd_c, inv_c, fwd_o, inv_o;
    logic          fwd_hot1, inv_hot1;
    logic          pos_val_ok, cfg_ok;

    assign shift_c    = sub_mod(pos_q, ring_q);
    assign pos_val_ok = ({1'b0, pos_val} < NW);
    assign cfg_ok     = cfg_we && ({1'b0, cfg_addr} < NW) && ({1'b0, cfg_data} < NW);
    assign fwd_hot1   = ($countones(fwd_in) == 1);
    assign inv_hot1   = ($countones(inv_in) == 1);

    // One-hot to index decode for both paths.
    always_comb begin
        fwd_idx = '0;
        inv_idx = '0;
        for (int i = 0; i < N_SYM; i++) begin
            if (fwd_in[i]) fwd_idx = IW'(i);
            if (inv_in[i]) inv_idx = IW'(i);
        end
    end

    assign fwd_c = add_mod(fwd_idx, shift_c);
    assign inv_c = add_mod(inv_idx, shift_c);
    assign fwd_o = sub_mod(wire_q[fwd_c], shift_c);
    assign inv_o = sub_mod(winv_q[inv_c], shift_c);

    // Output next-state: zero when idle or when the input was not one-hot.
    always_comb begin
        fwd_out_d = '0;
        inv_out_d = '0;
        sym_err_d = 1'b0;
        if (fwd_vld) begin
            if (fwd_hot1) fwd_out_d = N_SYM'(1) << fwd_o;
            else          sym_err_d = 1'b1;
        end
        if (inv_vld) begin
            if (inv_hot1) inv_out_d = N_SYM'(1) << inv_o;
            else          sym_err_d = 1'b1;
        end
    end

    // Position, ring, notch and carry next-state.
    always_comb begin
        pos_d   = pos_q;
        ring_d  = ring_q;
        notch_d = notch_q;
        carry_d = step_in && !pos_load && (pos_q == notch_q);
        if (pos_load) begin
            if (pos_val_ok) pos_d = pos_val;
        end else if (step_in) begin
            pos_d = add_mod(pos_q, IW'(1));
        end
        if (ring_load && pos_val_ok)  ring_d  = pos_val;
        if (notch_load && pos_val_ok) notch_d = pos_val;
    end

`ifdef ROTOR_PERM_CHECK_EN
    logic wr_rej;
    logic wire_ok_q, wire_ok_d;

    // A consistent table pair only stays a permutation if the write re-asserts the existing mapping.
    assign wr_rej   = cfg_ok && ((winv_q[cfg_data] != cfg_addr) || (wire_q[cfg_addr] != cfg_data));
    assign wr_apply = cfg_ok && !wr_rej;

    always_comb begin
        wire_ok_d = wire_ok_q;
        if (wr_rej)        wire_ok_d = 1'b0;
        else if (wr_apply) wire_ok_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) wire_ok_q <= 1'b1;
        else       wire_ok_q <= wire_ok_d;
    end

    assign wire_ok = wire_ok_q;
`else
    assign wr_apply = cfg_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SYM; i++) begin
                wire_q[i] <= IW'(i);
                winv_q[i] <= IW'(i);
            end
            pos_q     <= '0;
            ring_q    <= '0;
            notch_q   <= IW'(NOTCH_RST);
            carry_q   <= 1'b0;
            fwd_out_q <= '0;
            inv_out_q <= '0;
            fwd_vld_q <= 1'b0;
            inv_vld_q <= 1'b0;
            sym_err_q <= 1'b0;
        end else begin
            if (wr_apply) begin
                wire_q[cfg_addr] <= cfg_data;
                winv_q[cfg_data] <= cfg_addr;
            end
            pos_q     <= pos_d;
            ring_q    <= ring_d;
            notch_q   <= notch_d;
            carry_q   <= carry_d;
            fwd_out_q <= fwd_out_d;
            inv_out_q <= inv_out_d;
            fwd_vld_q <= fwd_vld;
            inv_vld_q <= inv_vld;
            sym_err_q <= sym_err_d;
        end
    end

    assign fwd_out     = fwd_out_q;
    assign fwd_out_vld = fwd_vld_q;
    assign inv_out     = inv_out_q;
    assign inv_out_vld = inv_vld_q;
    assign sym_err     = sym_err_q;
    assign pos         = pos_q;
    assign at_notch    = (pos_q == notch_q);
    assign carry_out   = carry_q;

endmodule

// File: tb/tb_rotor_stage.sv
// Directed scoreboard bench for rotor_stage: expectations queued at drive time, popped one cycle later.
module tb_rotor_stage;

    localparam int N  = 26;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  fwd_in, inv_in;
    logic          fwd_vld, inv_vld;
    logic [N-1:0]  fwd_out, inv_out;
    logic          fwd_out_vld, inv_out_vld, sym_err;
    logic          step_in, pos_load, ring_load, notch_load, cfg_we;
    logic [IW-1:0] pos_val, cfg_addr, cfg_data, pos;
    logic          at_notch, carry_out;
`ifdef ROTOR_PERM_CHECK_EN
    logic          wire_ok;
`endif

    rotor_stage #(.N_SYM(N), .NOTCH_RST(4)) dut (
        .clk(clk), .reset(reset),
        .fwd_in(fwd_in), .fwd_vld(fwd_vld), .inv_in(inv_in), .inv_vld(inv_vld),
        .fwd_out(fwd_out), .fwd_out_vld(fwd_out_vld),
        .inv_out(inv_out), .inv_out_vld(inv_out_vld), .sym_err(sym_err),
        .step_in(step_in), .pos_load(pos_load), .pos_val(pos_val),
        .ring_load(ring_load), .notch_load(notch_load),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pos(pos), .at_notch(at_notch), .carry_out(carry_out)
`ifdef ROTOR_PERM_CHECK_EN
        , .wire_ok(wire_ok)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] f;
        logic         fv;
        logic [N-1:0] i;
        logic         iv;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mw[N];
    int   minv[N];
    int   mpos, mring;
    string wiring = "AJDKSIRUXBLHWTMCQGZNPYFVOE";

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Reference encoder written with plain integer modulo.
    function automatic int menc(input int k, input bit fwd);
        int sh, c, t;
        sh = (mpos - mring + N) % N;
        c  = (k + sh) % N;
        t  = fwd ? mw[c] : minv[c];
        return (t - sh + N) % N;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] f, input logic fv, input logic [N-1:0] iv_sym,
                        input logic iv, input logic [N-1:0] ef, input logic [N-1:0] ei,
                        input logic eerr, input logic stp, input string tag);
        exp_t e;
        fwd_in = f; fwd_vld = fv; inv_in = iv_sym; inv_vld = iv; step_in = stp;
        e.f = ef; e.fv = fv; e.i = ei; e.iv = iv; e.err = eerr;
        q.push_back(e);
        tick();
        fwd_vld = 1'b0; inv_vld = 1'b0; step_in = 1'b0; fwd_in = '0; inv_in = '0;
        e = q.pop_front();
        chk({tag, ".fwd_out"}, 32'(fwd_out), 32'(e.f));
        chk({tag, ".fwd_vld"}, 32'(fwd_out_vld), 32'(e.fv));
        chk({tag, ".inv_out"}, 32'(inv_out), 32'(e.i));
        chk({tag, ".inv_vld"}, 32'(inv_out_vld), 32'(e.iv));
        chk({tag, ".sym_err"}, 32'(sym_err), 32'(e.err));
    endtask

    task automatic wr(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = IW'(a); cfg_data = IW'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic ld(input logic p, input logic r, input logic n, input int v);
        pos_load = p; ring_load = r; notch_load = n; pos_val = IW'(v);
        tick();
        pos_load = 1'b0; ring_load = 1'b0; notch_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fwd_in = '0; inv_in = '0; fwd_vld = 1'b0; inv_vld = 1'b0;
        step_in = 1'b0; pos_load = 1'b0; ring_load = 1'b0; notch_load = 1'b0;
        pos_val = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        for (int i = 0; i < N; i++) begin mw[i] = i; minv[i] = i; end
        mpos = 0; mring = 0;
        repeat (2) tick();
        chk("rst.fwd_out", 32'(fwd_out), 32'd0);
        chk("rst.vlds", 32'({fwd_out_vld, inv_out_vld}), 32'd0);
        chk("rst.sym_err", 32'(sym_err), 32'd0);
        chk("rst.carry", 32'(carry_out), 32'd0);
        chk("rst.pos", 32'(pos), 32'd0);
        chk("rst.at_notch", 32'(at_notch), 32'd0);
`ifdef ROTOR_PERM_CHECK_EN
        chk("rst.wire_ok", 32'(wire_ok), 32'd1);
`endif
        reset = 1'b0;
        tick();
        send(oh(2), 1'b1, oh(5), 1'b1, oh(2), oh(5), 1'b0, 1'b0, "identity");

`ifndef ROTOR_PERM_CHECK_EN
        for (int i = 0; i < N; i++) begin
            mw[i] = int'(wiring[i]) - 65;
            minv[mw[i]] = i;
            wr(i, mw[i]);
        end
        send(oh(0), 1'b1, '0, 1'b0, oh(0), '0, 1'b0, 1'b0, "rII.A");
        send(oh(1), 1'b1, '0, 1'b0, oh(9), '0, 1'b0, 1'b0, "rII.B");
        send(oh(2), 1'b1, oh(9), 1'b1, oh(3), oh(1), 1'b0, 1'b0, "rII.C_invJ");
        ld(1'b1, 1'b0, 1'b0, 1);
        chk("pos1", 32'(pos), 32'd1);
        send(oh(0), 1'b1, '0, 1'b0, oh(8), '0, 1'b0, 1'b0, "pos1.A");
        ld(1'b1, 1'b1, 1'b0, 0);
        ld(1'b0, 1'b1, 1'b0, 1);
        send(oh(0), 1'b1, '0, 1'b0, oh(5), '0, 1'b0, 1'b0, "ring1.A");
        ld(1'b0, 1'b1, 1'b0, 0);
`endif

        // Turnover at the notch, then wrap without carry.
        ld(1'b1, 1'b0, 1'b1, 4);
        chk("notch.at_notch", 32'(at_notch), 32'd1);
        step_in = 1'b1; tick(); step_in = 1'b0;
        chk("notch.pos", 32'(pos), 32'd5);
        chk("notch.carry", 32'(carry_out), 32'd1);
        tick();
        chk("notch.carry_pulse", 32'(carry_out), 32'd0);
        ld(1'b1, 1'b0, 1'b0, 25);
        step_in = 1'b1; tick(); step_in = 1'b0;
        chk("wrap.pos", 32'(pos), 32'd0);
        chk("wrap.carry", 32'(carry_out), 32'd0);

        // Same-cycle step uses the old position.
        send(oh(0), 1'b1, '0, 1'b0, oh(0), '0, 1'b0, 1'b1, "step_same");
        chk("step_same.pos", 32'(pos), 32'd1);
        ld(1'b1, 1'b0, 1'b0, 4);
        pos_load = 1'b1; pos_val = 5'd7; step_in = 1'b1;
        tick();
        pos_load = 1'b0; step_in = 1'b0;
        chk("load_beats_step.pos", 32'(pos), 32'd7);
        chk("load_beats_step.carry", 32'(carry_out), 32'd0);

        send('0, 1'b1, 26'h3, 1'b1, '0, '0, 1'b1, 1'b0, "badsym");
        send('0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, "idle");

        ld(1'b1, 1'b0, 1'b0, 3);
        ld(1'b0, 1'b1, 1'b0, 5);
        mpos = 3; mring = 5;
        for (int k = 0; k < N; k++)
            send(oh(k), 1'b1, oh(k), 1'b1, oh(menc(k, 1'b1)), oh(menc(k, 1'b0)), 1'b0, 1'b0, "sweep");

        wr(26, 0);
        wr(0, 30);
        send(oh(0), 1'b1, oh(0), 1'b1, oh(menc(0, 1'b1)), oh(menc(0, 1'b0)), 1'b0, 1'b0, "oob_write");

        // Reset while a symbol is in flight.
        fwd_in = oh(1); fwd_vld = 1'b1; reset = 1'b1;
        tick();
        fwd_vld = 1'b0; fwd_in = '0; reset = 1'b0;
        chk("midrst.fwd_out", 32'(fwd_out), 32'd0);
        chk("midrst.fwd_vld", 32'(fwd_out_vld), 32'd0);
        chk("midrst.pos", 32'(pos), 32'd0);
        send(oh(1), 1'b1, oh(9), 1'b1, oh(1), oh(9), 1'b0, 1'b0, "midrst.identity");

`ifdef ROTOR_PERM_CHECK_EN
        wr(0, 1);
        chk("perm.reject.wire_ok", 32'(wire_ok), 32'd0);
        send(oh(0), 1'b1, oh(1), 1'b1, oh(0), oh(1), 1'b0, 1'b0, "perm.unchanged");
        wr(0, 0);
        chk("perm.apply.wire_ok", 32'(wire_ok), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
